bus_arbiter: RTL and testbench

Arbitrates the single shared memory bus between the CPU's cache/memory port and the DMA controller. It sits between the DMA's `BR`/`BG` handshake and the CPU's memory request/complete signals, and guarantees the two masters are never granted at the same time. Each bus tenure is followed by a fixed turnaround, and ties are broken round-robin, so the DMA's cycle-stealing gaps actually let the CPU in. Two saturating counters report DMA bus occupancy and CPU stall cycles for performance checks.

---
 rtl/bus_arbiter_pkg.sv | 32 +++
 rtl/bus_arbiter_sat_counter.sv | 20 ++
 rtl/bus_arbiter.sv | 112 +++++++++++
 tb/tb_bus_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter.
// Owner and state encodings plus the tie-break rule.
package bus_arbiter_pkg;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_CPU  = 2'b01;
    localparam logic [1:0] OWNER_DMA  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_OWN = 2'd1,
        ST_DMA_OWN = 2'd2,
        ST_TURN    = 2'd3
    } arb_state_e;

    // Ties go to the master that did not own the previous tenure.
    function automatic arb_state_e arbitrate(
        input logic br,
        input logic req,
        input logic last_dma
    );
        if (br && req)
            return last_dma ? ST_CPU_OWN : ST_DMA_OWN;
        else if (br)
            return ST_DMA_OWN;
        else if (req)
            return ST_CPU_OWN;
        else
            return ST_IDLE;
    endfunction

endpackage

// File: rtl/bus_arbiter_sat_counter.sv
// Saturating up-counter used for bus statistics.
// Holds at all-ones; cleared only by reset.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count qualifying cycles, stop at the maximum value.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shared memory bus arbiter between CPU port and DMA.
// Round-robin ties, fixed turnaround, occupancy/stall stats.
import bus_arbiter_pkg::*;

module bus_arbiter #(
    parameter int TURNAROUND = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 BR,
    output logic                 BG,
    input  logic                 cpu_req,
    input  logic                 cpu_done,
    output logic                 cpu_grant,
    output logic [1:0]           bus_owner,
    output logic [CNT_WIDTH-1:0] dma_cycles,
    output logic [CNT_WIDTH-1:0] cpu_stall_cycles
);

    localparam logic [2:0] TURN_LOAD = 3'(TURNAROUND - 1);

    arb_state_e state, state_n;
    logic [2:0] turn_cnt, turn_cnt_n;
    logic       last_dma, last_dma_n;
    logic       stall_inc;

    // State, turnaround counter and last-owner registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= ST_IDLE;
            turn_cnt <= 3'd0;
            last_dma <= 1'b0;
        end else begin
            state    <= state_n;
            turn_cnt <= turn_cnt_n;
            last_dma <= last_dma_n;
        end
    end

    // Next state: owners run to completion, then a fixed idle gap.
    always_comb begin
        state_n    = state;
        turn_cnt_n = turn_cnt;
        last_dma_n = last_dma;
        unique case (state)
            ST_IDLE: begin
                state_n = arbitrate(BR, cpu_req, last_dma);
            end
            ST_CPU_OWN: begin
                if (cpu_done || !cpu_req) begin
                    state_n    = ST_TURN;
                    turn_cnt_n = TURN_LOAD;
                    last_dma_n = 1'b0;
                end
            end
            ST_DMA_OWN: begin
                if (!BR) begin
                    state_n    = ST_TURN;
                    turn_cnt_n = TURN_LOAD;
                    last_dma_n = 1'b1;
                end
            end
            ST_TURN: begin
                if (turn_cnt == 3'd0)
                    state_n = arbitrate(BR, cpu_req, last_dma);
                else
                    turn_cnt_n = turn_cnt - 3'd1;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Grants and owner are pure decodes of the state register.
    always_comb begin
        BG        = 1'b0;
        cpu_grant = 1'b0;
        bus_owner = OWNER_NONE;
        unique case (state)
            ST_CPU_OWN: begin
                cpu_grant = 1'b1;
                bus_owner = OWNER_CPU;
            end
            ST_DMA_OWN: begin
                BG        = 1'b1;
                bus_owner = OWNER_DMA;
            end
            default: begin
                bus_owner = OWNER_NONE;
            end
        endcase
    end

    assign stall_inc = cpu_req & ~cpu_grant;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_dma_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (BG),
        .count (dma_cycles)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .inc   (stall_inc),
        .count (cpu_stall_cycles)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: two instances
// (TURNAROUND=1/16-bit, TURNAROUND=3/4-bit) vs a timeline model.
module tb_bus_arbiter;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic BR = 1'b0;
    logic cpu_req = 1'b0;
    logic cpu_done = 1'b0;

    logic        bg0, cg0;
    logic [1:0]  own0;
    logic [15:0] dma0, stall0;
    logic        bg1, cg1;
    logic [1:0]  own1;
    logic [3:0]  dma1, stall1;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    bus_arbiter #(.TURNAROUND(1), .CNT_WIDTH(16)) dut0 (
        .CLK(CLK), .RESET(RESET), .BR(BR), .BG(bg0),
        .cpu_req(cpu_req), .cpu_done(cpu_done), .cpu_grant(cg0),
        .bus_owner(own0), .dma_cycles(dma0), .cpu_stall_cycles(stall0)
    );

    bus_arbiter #(.TURNAROUND(3), .CNT_WIDTH(4)) dut1 (
        .CLK(CLK), .RESET(RESET), .BR(BR), .BG(bg1),
        .cpu_req(cpu_req), .cpu_done(cpu_done), .cpu_grant(cg1),
        .bus_owner(own1), .dma_cycles(dma1), .cpu_stall_cycles(stall1)
    );

    // Reference model: owner timeline, release time and earliest next grant.
    typedef struct {
        int own;
        int dma;
        int stall;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int t_of[2]   = '{1, 3};
    int max_of[2] = '{65535, 15};
    int m_own[2];
    int m_last[2];
    int m_free[2];
    int m_dma[2];
    int m_stall[2];
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i] = 0; m_last[i] = 1; m_free[i] = 0;
            m_dma[i] = 0; m_stall[i] = 0;
        end
    endtask

    // Owner codes: 0 none, 1 CPU, 2 DMA.
    always @(posedge CLK) begin
        exp_t e;
        cyc++;
        if (RESET) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_own[i] == 2 && m_dma[i] < max_of[i]) m_dma[i]++;
                if (cpu_req && m_own[i] != 1 && m_stall[i] < max_of[i]) m_stall[i]++;
                if (m_own[i] == 1) begin
                    if (cpu_done || !cpu_req) begin
                        m_own[i] = 0; m_last[i] = 1; m_free[i] = cyc + t_of[i];
                    end
                end else if (m_own[i] == 2) begin
                    if (!BR) begin
                        m_own[i] = 0; m_last[i] = 2; m_free[i] = cyc + t_of[i];
                    end
                end else if (cyc >= m_free[i]) begin
                    if (BR && cpu_req) m_own[i] = (m_last[i] == 2) ? 1 : 2;
                    else if (BR) m_own[i] = 2;
                    else if (cpu_req) m_own[i] = 1;
                end
            end
        end
        e.own = m_own[0]; e.dma = m_dma[0]; e.stall = m_stall[0];
        q0.push_back(e);
        e.own = m_own[1]; e.dma = m_dma[1]; e.stall = m_stall[1];
        q1.push_back(e);
    end

    // Monitor: pop the expected response and compare after each edge.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        chk("mutex0", int'(bg0 & cg0), 0);
        chk("mutex1", int'(bg1 & cg1), 0);
        if (q0.size() == 0 || q1.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = q0.pop_front();
            chk("owner0", int'(own0), e.own);
            chk("bg0", int'(bg0), int'(e.own == 2));
            chk("cg0", int'(cg0), int'(e.own == 1));
            chk("dma0", int'(dma0), e.dma);
            chk("stall0", int'(stall0), e.stall);
            e = q1.pop_front();
            chk("owner1", int'(own1), e.own);
            chk("bg1", int'(bg1), int'(e.own == 2));
            chk("cg1", int'(cg1), int'(e.own == 1));
            chk("dma1", int'(dma1), e.dma);
            chk("stall1", int'(stall1), e.stall);
        end
    end

    task automatic step(input logic br, input logic req, input logic done);
        @(negedge CLK);
        BR = br; cpu_req = req; cpu_done = done;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        BR = 1'b0; cpu_req = 1'b0; cpu_done = 1'b0; RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic br, req;
        model_reset();
        repeat (2) @(negedge CLK);
        chk("rst_owner0", int'(own0), 0);
        chk("rst_bg0", int'(bg0), 0);
        chk("rst_cnt0", int'(dma0) + int'(stall0), 0);
        RESET = 1'b0;

        // DMA alone for 6 cycles.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        idle(5);
        chk("dma_six0", int'(dma0), 6);
        chk("dma_six1", int'(dma1), 6);

        // Simultaneous request after reset: DMA wins the first tie.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        idle(6);
        chk("stall_seven0", int'(stall0), 7);

        // Cycle-stealing DMA blocks with the CPU waiting throughout.
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) step(1'b1, 1'b1, cg0);
            step(1'b0, 1'b1, cg0);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, cg0);
        idle(8);

        // CPU tenure, DMA arrives mid-tenure, done pulse on cycle 5.
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of the DMA tenure.
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("async_bg0", int'(bg0), 0);
        chk("async_bg1", int'(bg1), 0);
        chk("async_own0", int'(own0), 0);
        chk("async_own1", int'(own1), 0);
        chk("async_cnt0", int'(dma0) + int'(stall0), 0);
        chk("async_cnt1", int'(dma1) + int'(stall1), 0);
        model_reset();
        #1 RESET = 1'b0;
        BR = 1'b0; cpu_req = 1'b0; cpu_done = 1'b0;
        idle(4);

        // Long DMA hold saturates the narrow counter.
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        idle(5);
        chk("sat_dma1", int'(dma1), 15);
        chk("sat_dma0", int'(dma0), 20);

        // Random traffic.
        br = 1'b0; req = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) br = ~br;
            if ($urandom_range(0, 3) == 0) req = ~req;
            step(br, req, logic'($urandom_range(0, 3) == 0));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
